// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the mul/div sequencer.
//   master (EX side): drives req_valid, req_op, req_word, srca, srcb, flush;
//                     observes req_ready, stall, resp_valid, result.
//   slave (sequencer): the mirror image.
interface muldiv_if #(
    parameter int unsigned XLEN = 64
) ();
    logic            req_valid;
    logic [2:0]      req_op;
    logic            req_word;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic            flush;
    logic            req_ready;
    logic            stall;
    logic            resp_valid;
    logic [XLEN-1:0] result;

    modport master (
        output req_valid, req_op, req_word, srca, srcb, flush,
        input  req_ready, stall, resp_valid, result
    );

    modport slave (
        input  req_valid, req_op, req_word, srca, srcb, flush,
        output req_ready, stall, resp_valid, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV/DIVU/MOD/MODU unit with its controller.
// Radix-2 shift-add multiply and restoring shift-subtract divide, one bit per
// cycle; divide-by-zero and signed overflow resolve in one cycle at accept.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus (slave)  req_valid/req_op/req_word/srca/srcb/flush in,
//                req_ready/stall/resp_valid/result out
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   MUL finishes once the remaining multiplier bits are zero, and a zero
//   multiplier takes the one-cycle fast path.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 64
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int unsigned HALF = XLEN / 2;
    localparam int unsigned CW   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_X = XLEN'(1) << (XLEN - 1);
    localparam logic [HALF-1:0] MIN_H = HALF'(1) << (HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            word_q;
    logic            is_div_q;
    logic            is_rem_q;
    logic            neg_q_q;   // quotient must be negated
    logic            neg_r_q;   // remainder must be negated
    logic [XLEN-1:0] opa;       // multiplicand, or dividend/quotient shift register
    logic [XLEN-1:0] opb;       // multiplier, or divisor magnitude
    logic [XLEN-1:0] acc;       // product, or partial remainder
    logic [XLEN-1:0] result_q;

    // Accept-time decode: operand magnitudes, signs and fast-path detection
    logic            acc_go;
    logic            is_div, is_signed, is_rem;
    logic [XLEN-1:0] a_ext, b_ext, a_src, b_src, a_mag, b_mag, q_load;
    logic            a_neg, b_neg, b_zero, a_min, b_m1;
    logic            spec_hit;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        acc_go    = (state == S_IDLE) && bus.req_valid && !bus.flush;
        is_div    = (bus.req_op >= 3'd1) && (bus.req_op <= 3'd4);
        is_signed = (bus.req_op == 3'd1) || (bus.req_op == 3'd3);
        is_rem    = (bus.req_op == 3'd3) || (bus.req_op == 3'd4);

        a_ext = bus.req_word ? {{HALF{bus.srca[HALF-1]}}, bus.srca[HALF-1:0]} : bus.srca;
        b_ext = bus.req_word ? {{HALF{bus.srcb[HALF-1]}}, bus.srcb[HALF-1:0]} : bus.srcb;
        a_src = is_signed ? a_ext
                          : (bus.req_word ? {{HALF{1'b0}}, bus.srca[HALF-1:0]} : bus.srca);
        b_src = is_signed ? b_ext
                          : (bus.req_word ? {{HALF{1'b0}}, bus.srcb[HALF-1:0]} : bus.srcb);
        a_neg = is_signed && a_src[XLEN-1];
        b_neg = is_signed && b_src[XLEN-1];
        a_mag = a_neg ? -a_src : a_src;
        b_mag = b_neg ? -b_src : b_src;
        // W dividend sits in the upper half so its MSB is shifted out first
        q_load = (is_div && bus.req_word) ? (a_mag << HALF) : a_mag;

        b_zero = bus.req_word ? (bus.srcb[HALF-1:0] == '0) : (bus.srcb == '0);
        a_min  = bus.req_word ? (bus.srca[HALF-1:0] == MIN_H) : (bus.srca == MIN_X);
        b_m1   = bus.req_word ? (&bus.srcb[HALF-1:0]) : (&bus.srcb);

        spec_hit = 1'b0;
        spec_res = '0;
        if (is_div && b_zero) begin
            spec_hit = 1'b1;
            spec_res = is_rem ? a_ext : '1;
        end else if (is_signed && a_min && b_m1) begin
            // a_ext already equals sext(MIN_N) here
            spec_hit = 1'b1;
            spec_res = is_rem ? '0 : a_ext;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!is_div && b_zero) begin
            spec_hit = 1'b1;
            spec_res = '0;
        end
`endif
    end

    // One iteration of the active loop plus the sign/width fix-up of its outcome
    logic [XLEN-1:0] prod_nx, rem_nx, q_nx, raw, fin;
    logic [XLEN:0]   shifted, diff;
    logic            ge, last;

    always_comb begin
        prod_nx = opb[0] ? (acc + opa) : acc;
        shifted = {acc, opa[XLEN-1]};
        diff    = shifted - {1'b0, opb};
        ge      = !diff[XLEN];
        rem_nx  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        q_nx    = {opa[XLEN-2:0], ge};

        if (!is_div_q)
            raw = prod_nx;
        else if (is_rem_q)
            raw = neg_r_q ? -rem_nx : rem_nx;
        else
            raw = neg_q_q ? -q_nx : q_nx;
        fin = word_q ? {{HALF{raw[HALF-1]}}, raw[HALF-1:0]} : raw;

        last = (count == '0);
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div_q && ((opb >> 1) == '0))
            last = 1'b1;
`endif
    end

    // Controller and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            word_q   <= 1'b0;
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (acc_go) begin
                        word_q   <= bus.req_word;
                        is_div_q <= is_div;
                        is_rem_q <= is_rem;
                        neg_q_q  <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        if (spec_hit) begin
                            result_q <= spec_res;
                            state    <= S_DONE;
                        end else begin
                            opa   <= q_load;
                            opb   <= b_mag;
                            acc   <= '0;
                            count <= bus.req_word ? CW'(HALF - 1) : CW'(XLEN - 1);
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (is_div_q) begin
                            opa <= q_nx;
                            acc <= rem_nx;
                        end else begin
                            opa <= opa << 1;
                            opb <= opb >> 1;
                            acc <= prod_nx;
                        end
                        count <= count - CW'(1);
                        if (last) begin
                            result_q <= fin;
                            state    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs; stall lets EX advance in DONE so it captures the result
    assign bus.req_ready  = (state == S_IDLE);
    assign bus.stall      = ((state == S_IDLE) && bus.req_valid && !bus.flush) || (state == S_BUSY);
    assign bus.resp_valid = (state == S_DONE) && !bus.flush;
    assign bus.result     = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; a scoreboard queue holds expected result
// and response cycle per issued op, a negedge monitor pops on each resp_valid.
module tb_muldiv_sequencer;
    localparam int unsigned XLEN = 64;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    logic [XLEN-1:0] exp_res[$];
    int              exp_cyc[$];

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && bus.resp_valid) begin
            if (exp_res.size() == 0) begin
                check("unexpected_resp", 64'd1, 64'd0);
            end else begin
                logic [XLEN-1:0] r;
                int              c;
                r = exp_res.pop_front();
                c = exp_cyc.pop_front();
                check("resp_result", bus.result, r);
                check("resp_cycle", XLEN'(cyc), XLEN'(c));
            end
        end
    end

    // Called just after a posedge with the DUT idle; returns accept cycle T
    task automatic issue(input logic [2:0] op, input logic word, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input int lat, input logic [XLEN-1:0] res,
                         input logic push, output int t);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_word  = word;
        bus.srca      = a;
        bus.srcb      = b;
        t = cyc;
        if (push) begin
            exp_res.push_back(res);
            exp_cyc.push_back(t + lat);
        end
        #1 check("stall_at_accept", XLEN'(bus.stall), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom_range(0, 7));
        bus.srca      = {$urandom, $urandom};
        bus.srcb      = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.req_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.req_ready) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_res.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        wait_idle();
    endtask

    localparam logic [2:0] OP_MUL = 3'd0, OP_DIV = 3'd1, OP_DIVU = 3'd2, OP_MOD = 3'd3, OP_MODU = 3'd4;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_MULW = 18;
    localparam int LAT_MUL53 = 3;
`else
    localparam int LAT_MULW = 33;
    localparam int LAT_MUL53 = 65;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int bad;
        cyc = 0;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_word  = 1'b0;
        bus.srca      = '0;
        bus.srcb      = '0;
        bus.flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_ready", XLEN'(bus.req_ready), 64'd1);
        check("rst_stall", XLEN'(bus.stall), 64'd0);
        check("rst_resp_valid", XLEN'(bus.resp_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);

        // MUL 7 x -3 with stall profile
        issue(OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, t);
        bad = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (!bus.stall) bad++;
        end
        check("stall_busy_lows", XLEN'(bad), 64'd0);
        @(negedge clk);
        check("stall_done", XLEN'(bus.stall), 64'd0);
        wait_drain();

        // Divide/remainder sign handling
        issue(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, t);
        wait_idle();
        issue(OP_MOD, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, t);
        wait_idle();
        issue(OP_DIVU, 1'b0, 64'd100, 64'd7, 65, 64'd14, 1'b1, t);
        wait_idle();
        issue(OP_MODU, 1'b0, 64'd100, 64'd7, 65, 64'd2, 1'b1, t);
        wait_idle();

        // Divide by zero fast path
        issue(OP_DIVU, 1'b0, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, t);
        wait_idle();
        issue(OP_MOD, 1'b0, 64'd5, 64'd0, 1, 64'd5, 1'b1, t);
        wait_idle();

        // W variants: signed overflow and wrapped product
        issue(OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1,
              64'hFFFF_FFFF_8000_0000, 1'b1, t);
        wait_idle();
        issue(OP_MUL, 1'b1, 64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, LAT_MULW,
              64'd0, 1'b1, t);
        wait_drain();

        // Flush in the 10th BUSY cycle, then back-to-back DIVU
        issue(OP_DIVU, 1'b0, 64'd100, 64'd7, 65, 64'd0, 1'b0, t);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("flush_resp_gated", XLEN'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("flush_req_ready", XLEN'(bus.req_ready), 64'd1);
        check("flush_cycle", XLEN'(cyc), XLEN'(t + 11));
        issue(OP_DIVU, 1'b0, 64'd9, 64'd3, 65, 64'd3, 1'b1, t);
        wait_drain();

        // Reset asserted while BUSY
        issue(OP_MUL, 1'b0, 64'd7, 64'd3, 65, 64'd0, 1'b0, t);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_req_ready", XLEN'(bus.req_ready), 64'd1);
        check("midrst_stall", XLEN'(bus.stall), 64'd0);
        check("midrst_resp_valid", XLEN'(bus.resp_valid), 64'd0);
        check("midrst_result", bus.result, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (80) @(posedge clk);
        #1;

        // Small multiply, early-out sensitive latency
        issue(OP_MUL, 1'b0, 64'd5, 64'd3, LAT_MUL53, 64'd15, 1'b1, t);
        wait_drain();

        check("scoreboard_empty", XLEN'(exp_res.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
